// File: rtl/reg_mem_pkg.sv
// Shared types and helpers for the register-memory burst reader.
//   reg_mem_rd_state_t : burst FSM states
//   SKID_DEPTH         : output buffer depth; the credit limit equals this
//   nextAddr()         : address increment with wrap at an arbitrary height
package reg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reg_mem_rd_state_t;

  localparam int unsigned SKID_DEPTH = 2;

  // Height need not be a power of two, so wrap explicitly at height-1.
  function automatic int unsigned nextAddr(input int unsigned addr,
                                           input int unsigned height);
    return (addr == height - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/reg_mem_skid_fifo.sv
// Two-entry FIFO of {last, data} words sitting between the memory read port
// and the output stream.
//   clk_i, rst_ni          : clock, async active-low reset
//   push_i/push_last_i/
//   push_data_i            : write one tagged word
//   pop_i                  : remove head word (only when head_valid_o)
//   count_o                : occupancy 0..2
//   head_valid_o/head_last_o/
//   head_data_o            : registered head of queue
module reg_mem_skid_fifo
  import reg_mem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             push_last_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             head_valid_o,
  output logic             head_last_o,
  output logic [WIDTH-1:0] head_data_o
);

  logic [SKID_DEPTH-1:0][WIDTH:0] mem_q;
  logic                           wr_ptr_q;
  logic                           rd_ptr_q;
  logic [1:0]                     count_q;

  // Push into a full FIFO is only legal together with a pop: in that case
  // wr_ptr == rd_ptr and the slot being overwritten is the one leaving.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_last_o  = mem_q[rd_ptr_q][WIDTH];
  assign head_data_o  = mem_q[rd_ptr_q][WIDTH-1:0];

endmodule

// File: rtl/reg_mem_burst_reader.sv
// Burst read master for a register memory with a 1-cycle registered read.
// Accepts {addr, len} commands, issues one read per cycle while credit
// allows, and streams the returned words on a valid/ready port with a last
// flag.
//   clk_i, rst_ni                   : clock, async active-low reset
//   cmdValid_i/cmdReady_o/
//   cmdAddr_i/cmdLen_i              : burst command
//   memReadEnable_o/memReadAddr_o/
//   memReadData_i                   : memory read port (data one cycle later)
//   outValid_o/outReady_i/
//   outData_o/outLast_o             : output stream
//   busy_o                          : high whenever a burst is in progress
module reg_mem_burst_reader
  import reg_mem_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmdValid_i,
  output logic                      cmdReady_o,
  input  logic [$clog2(HEIGHT)-1:0] cmdAddr_i,
  input  logic [$clog2(HEIGHT+1)-1:0] cmdLen_i,
  output logic                      memReadEnable_o,
  output logic [$clog2(HEIGHT)-1:0] memReadAddr_o,
  input  logic [WIDTH-1:0]          memReadData_i,
  output logic                      outValid_o,
  input  logic                      outReady_i,
  output logic [WIDTH-1:0]          outData_o,
  output logic                      outLast_o,
  output logic                      busy_o
);

  localparam int LEN_W  = $clog2(HEIGHT + 1);
  localparam int ADDR_W = $clog2(HEIGHT);

  reg_mem_rd_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              in_flight_q;
  logic              in_flight_last_q;

  logic [1:0] buf_count;
  logic       head_valid;
  logic       head_last;
  logic       pop;
  logic       issue;
  logic       final_issue;
  logic       start;
  logic [2:0] occupancy;

  assign pop = outValid_o & outReady_i;

  // Words owed to the buffer: the read in flight plus what is stored, less
  // the word leaving this cycle. Staying below the depth guarantees the
  // in-flight word always has a slot when it lands.
  assign occupancy   = {2'b0, in_flight_q} + {1'b0, buf_count} - {2'b0, pop};
  assign issue       = (state_q == RUN) && (occupancy < 3'(SKID_DEPTH));
  assign final_issue = issue && (rem_q == LEN_W'(1));
  assign start       = (state_q == IDLE) && cmdValid_i && (cmdLen_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmdReady_o = 1'b0;
    case (state_q)
      IDLE: begin
        cmdReady_o = 1'b1;
        // Zero-length commands are accepted and dropped.
        if (start) state_d = RUN;
      end
      RUN: begin
        if (final_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && outLast_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q           <= '0;
      rem_q            <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      if (start) begin
        addr_q <= cmdAddr_i;
        rem_q  <= cmdLen_i;
      end else if (issue) begin
        addr_q <= ADDR_W'(nextAddr(32'(addr_q), 32'(HEIGHT)));
        rem_q  <= rem_q - LEN_W'(1);
      end
      in_flight_q      <= issue;
      in_flight_last_q <= final_issue;
    end
  end

  assign memReadEnable_o = issue;
  assign memReadAddr_o   = addr_q;

  reg_mem_skid_fifo #(.WIDTH(WIDTH)) u_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (in_flight_q),
    .push_last_i  (in_flight_last_q),
    .push_data_i  (memReadData_i),
    .pop_i        (pop),
    .count_o      (buf_count),
    .head_valid_o (head_valid),
    .head_last_o  (head_last),
    .head_data_o  (outData_o)
  );

  assign outValid_o = head_valid;
  assign outLast_o  = head_valid & head_last;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_mem_burst_reader.sv
module tb_reg_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  // instance A: HEIGHT=16
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic        mre;
  logic [3:0]  mra;
  logic [15:0] mrd = '0;
  logic        out_valid, out_ready = 1'b1, out_last, busy;
  logic [15:0] out_data;
  // instance B: HEIGHT=10
  logic        cmd_valid_b = 1'b0, cmd_ready_b;
  logic [3:0]  cmd_addr_b = '0;
  logic [3:0]  cmd_len_b = '0;
  logic        mre_b;
  logic [3:0]  mra_b;
  logic [15:0] mrd_b = '0;
  logic        out_valid_b, out_last_b, busy_b;
  logic        out_ready_b = 1'b1;
  logic [15:0] out_data_b;

  int total = 0, bad = 0;
  int cyc = 0;
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [10];

  logic [16:0] exp_q[$];
  int          addr_exp[$];
  int          pop_log[$];
  int          addr_log_b[$];
  logic [16:0] word_log_b[$];
  int issued = 0, popped = 0, stall_noissue = 0;
  int last_pop_cyc = -1, hs_cyc = -1;
  logic hs_busy = 1'b0, busy_at_last = 1'b0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  logic bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;

  reg_mem_burst_reader #(.WIDTH(16), .HEIGHT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmdValid_i(cmd_valid), .cmdReady_o(cmd_ready),
    .cmdAddr_i(cmd_addr), .cmdLen_i(cmd_len),
    .memReadEnable_o(mre), .memReadAddr_o(mra), .memReadData_i(mrd),
    .outValid_o(out_valid), .outReady_i(out_ready),
    .outData_o(out_data), .outLast_o(out_last), .busy_o(busy));

  reg_mem_burst_reader #(.WIDTH(16), .HEIGHT(10)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cmdValid_i(cmd_valid_b), .cmdReady_o(cmd_ready_b),
    .cmdAddr_i(cmd_addr_b), .cmdLen_i(cmd_len_b),
    .memReadEnable_o(mre_b), .memReadAddr_o(mra_b), .memReadData_i(mrd_b),
    .outValid_o(out_valid_b), .outReady_i(out_ready_b),
    .outData_o(out_data_b), .outLast_o(out_last_b), .busy_o(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i * 17);
    for (int i = 0; i < 10; i++) mem_b[i] = 16'(i * 17);
  end

  // registered-read memories, output holds when not enabled
  always @(posedge clk) begin
    if (mre)   mrd   <= mem_a[mra];
    if (mre_b && mra_b < 4'd10) mrd_b <= mem_b[mra_b];
  end

  // consumer backpressure 1,0,0,1 repeating
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #2;
      if (bp_mode) begin out_ready = bp_pat[ph % 4]; ph++; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    total++; bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // scoreboard monitor for instance A
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); addr_exp.delete();
      issued = 0; popped = 0; prev_stall = 1'b0;
    end else begin
      int outstanding;
      logic pop_now;
      logic [16:0] e;
      outstanding = issued - popped;
      pop_now = out_valid && out_ready;
      if (mre) chk("credit", 32'(outstanding - int'(pop_now) < 2), 32'd1);
      if (!mre && addr_exp.size() > 0 && outstanding - int'(pop_now) >= 2)
        stall_noissue++;
      if (mre) begin
        if (addr_exp.size() == 0) flag_fail("stray_read");
        else chk("rd_addr", 32'(mra), 32'(addr_exp.pop_front()));
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (pop_now) begin
        if (exp_q.size() == 0) flag_fail("stray_word");
        else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[15:0]));
          chk("out_last", 32'(out_last), 32'(e[16]));
        end
        popped++;
        pop_log.push_back(cyc);
        if (out_last) begin last_pop_cyc = cyc; busy_at_last = busy; end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // logger for instance B
  always @(negedge clk) begin
    if (rst_n) begin
      if (mre_b) addr_log_b.push_back(int'(mra_b));
      if (out_valid_b && out_ready_b) word_log_b.push_back({out_last_b, out_data_b});
    end
  end

  task automatic send(input int a, input int l);
    bit got = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 4'(a); cmd_len = 5'(l);
    for (int n = 0; n < 300 && !got; n++) begin
      if (n > 0) @(negedge clk);
      if (cmd_ready) begin
        got = 1; hs_cyc = cyc; hs_busy = busy;
        for (int k = 0; k < l; k++) begin
          addr_exp.push_back((a + k) % 16);
          exp_q.push_back({(k == l - 1), 16'(((a + k) % 16) * 17)});
        end
      end
    end
    if (!got) flag_fail("cmd_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && addr_exp.size() == 0 && !busy) done = 1;
    end
    if (!done) flag_fail("burst_timeout");
  endtask

  initial begin
    int p0;
    bit ok;
    // reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mre", 32'(mre), 32'd0);
    chk("rst_mra", 32'(mra), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // basic: addr 3 len 4, latency and back-to-back words
    pop_log.delete();
    send(3, 4);
    chk("lat_e0", 32'(out_valid), 32'd0);
    @(posedge clk); #1; chk("lat_e1", 32'(out_valid), 32'd0);
    @(posedge clk); #1; chk("lat_e2", 32'(out_valid), 32'd1);
    wait_done();
    chk("basic_pops", 32'(pop_log.size()), 32'd4);
    if (pop_log.size() == 4) chk("basic_rate", 32'(pop_log[3] - pop_log[0]), 32'd3);

    // wrap at 16
    send(14, 4);
    wait_done();

    // backpressure
    stall_noissue = 0;
    bp_mode = 1'b1;
    send(0, 8);
    wait_done();
    bp_mode = 1'b0; out_ready = 1'b1;
    chk("bp_credit_stall", 32'(stall_noissue > 0), 32'd1);

    // zero length
    send(7, 0);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #2;
      chk("len0_ready", 32'(cmd_ready), 32'd1);
      chk("len0_mre", 32'(mre), 32'd0);
      chk("len0_valid", 32'(out_valid), 32'd0);
    end

    // full length from addr 5
    pop_log.delete();
    send(5, 16);
    wait_done();
    chk("full_pops", 32'(pop_log.size()), 32'd16);

    // back-to-back commands
    send(2, 3);
    send(9, 2);
    chk("b2b_accept_cycle", 32'(hs_cyc), 32'(last_pop_cyc + 1));
    chk("b2b_busy_gap", 32'(hs_busy), 32'd0);
    chk("b2b_busy_before", 32'(busy_at_last), 32'd1);
    chk("b2b_busy_after", 32'(busy), 32'd1);
    wait_done();

    // non-power-of-two wrap on HEIGHT=10
    @(negedge clk); cmd_valid_b = 1'b1; cmd_addr_b = 4'd8; cmd_len_b = 4'd3;
    @(posedge clk); #1; cmd_valid_b = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("h10_nreads", 32'(addr_log_b.size()), 32'd3);
    chk("h10_nwords", 32'(word_log_b.size()), 32'd3);
    if (addr_log_b.size() == 3) begin
      chk("h10_addr0", 32'(addr_log_b[0]), 32'd8);
      chk("h10_addr1", 32'(addr_log_b[1]), 32'd9);
      chk("h10_addr2", 32'(addr_log_b[2]), 32'd0);
    end
    if (word_log_b.size() == 3) begin
      chk("h10_word0", 32'(word_log_b[0]), 32'h00088);
      chk("h10_word1", 32'(word_log_b[1]), 32'h00099);
      chk("h10_word2", 32'(word_log_b[2]), 32'h10000);
    end

    // reset mid-burst after 2 of 6 words
    p0 = popped;
    send(0, 6);
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(posedge clk); #2;
      if (popped - p0 >= 2) ok = 1;
    end
    if (!ok) flag_fail("midrst_timeout");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_mre", 32'(mre), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
